ofs_plat_prim_uid_arb: RTL and testbench

- Shares one UID allocator (alloc/alloc_ready/alloc_uid, free/free_uid interface) among N_PORTS requesters.
- Round-robin arbitration for allocations and, independently, for frees.
- Enforces a per-port outstanding-UID limit; records the owner of each UID so credits return to the correct port.
- Sits between tagging clients (e.g. per-channel read engines) and the shared UID pool; flags protocol errors.

---
 rtl/ofs_plat_prim_uid_arb_pkg.sv | 40 ++++
 rtl/ofs_plat_prim_rr_arb.sv | 64 ++++++
 rtl/ofs_plat_prim_uid_arb.sv | 179 +++++++++++++++++
 tb/tb_ofs_plat_prim_uid_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_plat_prim_uid_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ofs_plat_prim_uid_arb_pkg
// Purpose : Shared types, default sizes and helpers for the UID arbiter.
//           The typedefs describe the default configuration. The top level
//           derives its own widths from its parameters, so a non-default
//           instance never depends on these typedefs.
// Revision: 1.0  initial release
// ============================================================================
package ofs_plat_prim_uid_arb_pkg;

    localparam int UID_ARB_N_PORTS         = 4;
    localparam int UID_ARB_N_ENTRIES       = 32;
    localparam int UID_ARB_MAX_OUTSTANDING = 8;

    localparam int UID_ARB_UID_W    = $clog2(UID_ARB_N_ENTRIES);
    localparam int UID_ARB_PORT_W   = $clog2(UID_ARB_N_PORTS);
    localparam int UID_ARB_CREDIT_W = $clog2(UID_ARB_MAX_OUTSTANDING + 1);

    typedef logic [UID_ARB_UID_W-1:0]    t_uid;
    typedef logic [UID_ARB_PORT_W-1:0]   t_port_idx;
    typedef logic [UID_ARB_CREDIT_W-1:0] t_credit;

    // Widest packed per-port vector that get_slice() can index.
    localparam int SLICE_VEC_W = 1024;

    // Return field 'idx' of a packed vector made of 'width'-bit fields.
    // Fields wider than 32 bits are not supported.
    function automatic logic [31:0] get_slice(input logic [SLICE_VEC_W-1:0] vec,
                                              input int unsigned            width,
                                              input int unsigned            idx);
        logic [SLICE_VEC_W-1:0] shifted;
        logic [31:0]            mask;
        shifted = vec >> (width * idx);
        mask    = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofs_plat_prim_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : ofs_plat_prim_rr_arb
// Purpose : Round-robin arbiter. Picks one requester per cycle and returns a
//           one-hot grant. The search starts at the pointer. When en_i is
//           high and a grant is issued, the pointer moves to the port after
//           the winner.
// Ports   : clk, reset    clock, async active-high reset (pointer -> port 0)
//           req_i         request vector
//           en_i          allow the pointer to advance this cycle
//           gnt_o         one-hot grant (zero when no request)
//           gnt_idx_o     index of the granted port
//           gnt_any_o     any grant this cycle
// Revision: 1.0  initial release
// ============================================================================
module ofs_plat_prim_rr_arb #(
    parameter  int N_PORTS = 4,
    localparam int IDX_W   = $clog2(N_PORTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PORTS-1:0] req_i,
    input  logic               en_i,
    output logic [N_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = (int'(ptr_q) + i) % N_PORTS;
            if (!gnt_any_o && req_i[IDX_W'(idx)]) begin
                gnt_any_o            = 1'b1;
                gnt_o[IDX_W'(idx)]   = 1'b1;
                gnt_idx_o            = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && gnt_any_o) begin
            ptr_d = (gnt_idx_o == IDX_W'(N_PORTS - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofs_plat_prim_uid_arb.sv
`default_nettype none
// ============================================================================
// Module  : ofs_plat_prim_uid_arb
// Purpose : Shares one UID allocator among N_PORTS requesters. Allocation and
//           free each use their own round-robin arbiter. A per-port
//           outstanding limit is enforced, and the owner of each UID is
//           recorded so the credit returns to the right port. Protocol
//           errors are flagged on err.
// Ports   : clk, reset      clock, async active-high reset
//           req_valid/ready per-port UID request / acceptance (comb)
//           grant_valid/uid registered UID delivery, 1 cycle after accept
//           free_valid/uid  per-port UID return (packed UID per port)
//           free_ready      free acceptance (comb)
//           alloc/ready/uid allocator consume handshake
//           free/free_uid_out registered release to the allocator
//           outstanding     packed per-port held count
//           err             sticky protocol error
// Revision: 1.0  initial release
// ============================================================================
module ofs_plat_prim_uid_arb
    import ofs_plat_prim_uid_arb_pkg::*;
#(
    parameter  int N_PORTS         = UID_ARB_N_PORTS,
    parameter  int N_ENTRIES       = UID_ARB_N_ENTRIES,
    parameter  int MAX_OUTSTANDING = UID_ARB_MAX_OUTSTANDING,
    localparam int UID_W           = $clog2(N_ENTRIES),
    localparam int PORT_W          = $clog2(N_PORTS),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PORTS-1:0]         req_valid,
    output logic [N_PORTS-1:0]         req_ready,
    output logic [N_PORTS-1:0]         grant_valid,
    output logic [UID_W-1:0]           grant_uid,
    input  logic [N_PORTS-1:0]         free_valid,
    input  logic [N_PORTS*UID_W-1:0]   free_uid,
    output logic [N_PORTS-1:0]         free_ready,
    output logic                       alloc,
    input  logic                       alloc_ready,
    input  logic [UID_W-1:0]           alloc_uid,
    output logic                       free,
    output logic [UID_W-1:0]           free_uid_out,
    output logic [N_PORTS*CNT_W-1:0]   outstanding,
    output logic                       err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]   cnt_q [N_PORTS];
    logic [N_ENTRIES-1:0] busy_q;
    logic [N_ENTRIES-1:0] busy_d;
    logic [PORT_W-1:0]  owner_q [N_ENTRIES];

    logic [N_PORTS-1:0] grant_valid_q;
    logic [UID_W-1:0]   grant_uid_q;
    logic               free_q;
    logic [UID_W-1:0]   free_uid_q;
    logic               err_q;

    logic [N_PORTS-1:0] elig;
    logic [N_PORTS-1:0] a_req, a_gnt, f_req, f_gnt;
    logic [PORT_W-1:0]  a_idx, f_idx;
    logic               a_any, f_any;
    logic [N_PORTS-1:0] cnt_inc, cnt_dec;

    logic [UID_W-1:0]   fr_uid;
    logic               fr_busy;
    logic [PORT_W-1:0]  fr_owner;
    logic               fr_err;
    logic               collide;

    // ------------------------------------------------------------------
    // Arbitration. Both request vectors are gated by reset so that the
    // combinational handshakes are also 0 while reset is asserted.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < N_PORTS; p++) begin : g_elig
        assign elig[p] = req_valid[p] && (cnt_q[p] < MAX_CNT);
    end

    assign a_req = elig & {N_PORTS{alloc_ready & ~reset}};
    assign f_req = free_valid & {N_PORTS{~reset}};

    ofs_plat_prim_rr_arb #(.N_PORTS(N_PORTS)) u_alloc_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (a_req),
        .en_i      (alloc_ready & ~reset),
        .gnt_o     (a_gnt),
        .gnt_idx_o (a_idx),
        .gnt_any_o (a_any)
    );

    ofs_plat_prim_rr_arb #(.N_PORTS(N_PORTS)) u_free_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (f_req),
        .en_i      (~reset),
        .gnt_o     (f_gnt),
        .gnt_idx_o (f_idx),
        .gnt_any_o (f_any)
    );

    assign req_ready  = a_gnt;
    assign alloc      = a_any;
    assign free_ready = f_gnt;

    // ------------------------------------------------------------------
    // Free-path lookup. Owner and busy are read before this cycle's
    // update, so a colliding alloc does not hide the free's error.
    // ------------------------------------------------------------------
    assign fr_uid   = UID_W'(get_slice(SLICE_VEC_W'(free_uid), UID_W, 32'(f_idx)));
    assign fr_busy  = busy_q[fr_uid];
    assign fr_owner = owner_q[fr_uid];
    assign fr_err   = f_any && (!fr_busy || (fr_owner != f_idx));
    assign collide  = f_any && a_any && (fr_uid == alloc_uid);

    // The credit goes back to the recorded owner, not to the port that
    // freed the UID. A free of an idle UID returns no credit.
    for (genvar p = 0; p < N_PORTS; p++) begin : g_cnt
        assign cnt_inc[p] = a_gnt[p];
        assign cnt_dec[p] = f_any && fr_busy && (fr_owner == PORT_W'(p));
        assign outstanding[p*CNT_W +: CNT_W] = cnt_q[p];
    end

    // Clear first, then set, so an alloc wins a same-UID collision.
    always_comb begin
        busy_d = busy_q;
        if (f_any) busy_d[fr_uid]    = 1'b0;
        if (a_any) busy_d[alloc_uid] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < N_PORTS; p++) cnt_q[p] <= '0;
            busy_q        <= '0;
            grant_valid_q <= '0;
            grant_uid_q   <= '0;
            free_q        <= 1'b0;
            free_uid_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                case ({cnt_inc[p], cnt_dec[p]})
                    2'b10:   cnt_q[p] <= cnt_q[p] + 1'b1;
                    2'b01:   cnt_q[p] <= cnt_q[p] - 1'b1;
                    default: cnt_q[p] <= cnt_q[p];
                endcase
            end
            busy_q        <= busy_d;
            grant_valid_q <= a_gnt;
            grant_uid_q   <= a_any ? alloc_uid : '0;
            free_q        <= f_any;
            free_uid_q    <= f_any ? fr_uid : '0;
            if (fr_err || collide) err_q <= 1'b1;
        end
    end

    // The owner table needs no reset: it is only consulted for busy UIDs.
    always_ff @(posedge clk) begin
        if (a_any) owner_q[alloc_uid] <= a_idx;
    end

    assign grant_valid  = grant_valid_q;
    assign grant_uid    = grant_uid_q;
    assign free         = free_q;
    assign free_uid_out = free_uid_q;
    assign err          = err_q;

    // Credit counters must never wrap.
    for (genvar p = 0; p < N_PORTS; p++) begin : g_cnt_chk
        a_no_overflow : assert property (@(posedge clk) disable iff (reset)
            !(cnt_inc[p] && !cnt_dec[p] && (cnt_q[p] == MAX_CNT)));
        a_no_underflow : assert property (@(posedge clk) disable iff (reset)
            !(cnt_dec[p] && !cnt_inc[p] && (cnt_q[p] == '0)));
    end

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_prim_uid_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_ofs_plat_prim_uid_arb
// Purpose : Self-checking bench for ofs_plat_prim_uid_arb. A behavioural
//           model keeps per-UID owner/busy state, per-port credit counts and
//           rotation pointers. The model gives the expected handshakes and
//           registered outputs for every cycle. The bench also acts as the
//           UID pool and issues frees of UIDs each port really holds.
// Revision: 1.0  initial release
// ============================================================================
module tb_ofs_plat_prim_uid_arb;

    localparam int NP = 4;
    localparam int NE = 32;
    localparam int MO = 8;
    localparam int UW = 5;
    localparam int CW = 4;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     grant_valid;
    logic [UW-1:0]     grant_uid;
    logic [NP-1:0]     free_valid;
    logic [NP*UW-1:0]  free_uid;
    logic [NP-1:0]     free_ready;
    logic              alloc;
    logic              alloc_ready;
    logic [UW-1:0]     alloc_uid;
    logic              free;
    logic [UW-1:0]     free_uid_out;
    logic [NP*CW-1:0]  outstanding;
    logic              err;

    ofs_plat_prim_uid_arb #(.N_PORTS(NP), .N_ENTRIES(NE), .MAX_OUTSTANDING(MO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .grant_valid  (grant_valid),
        .grant_uid    (grant_uid),
        .free_valid   (free_valid),
        .free_uid     (free_uid),
        .free_ready   (free_ready),
        .alloc        (alloc),
        .alloc_ready  (alloc_ready),
        .alloc_uid    (alloc_uid),
        .free         (free),
        .free_uid_out (free_uid_out),
        .outstanding  (outstanding),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int  m_cnt   [NP];
    bit  m_busy  [NE];
    int  m_owner [NE];
    int  m_aptr, m_fptr;
    bit  m_err;
    int  m_gv, m_guid, m_free, m_fuid;   // expected registered outputs
    int  held [NP][$];                   // UIDs each port holds
    int  pool [$];                       // allocator free list

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_cnt[p] = 0;
            held[p].delete();
        end
        for (int u = 0; u < NE; u++) m_busy[u] = 1'b0;
        m_aptr = 0; m_fptr = 0; m_err = 1'b0;
        m_gv = 0; m_guid = 0; m_free = 0; m_fuid = 0;
        pool.delete();
        for (int u = 0; u < NE; u++) pool.push_back(u);
    endtask

    // Called just after a rising edge: apply inputs, check at the falling
    // edge, advance the model, then step to just after the next edge.
    task automatic run_cycle(input logic [NP-1:0] rv, input logic ar, input int au,
                             input logic [NP-1:0] fv, input logic [NP*UW-1:0] fu);
        int aw, fw, p, u, o;
        req_valid   = rv;
        alloc_ready = ar;
        alloc_uid   = UW'(au);
        free_valid  = fv;
        free_uid    = fu;
        @(negedge clk);

        aw = -1;
        fw = -1;
        u  = 0;
        for (int i = 0; i < NP; i++) begin
            p = (m_aptr + i) % NP;
            if (aw < 0 && ar && rv[p] && m_cnt[p] < MO) aw = p;
            p = (m_fptr + i) % NP;
            if (fw < 0 && fv[p]) fw = p;
        end

        check("req_ready",  32'(req_ready),  (aw >= 0) ? (32'd1 << aw) : 32'd0);
        check("alloc",      32'(alloc),      32'(aw >= 0));
        check("free_ready", 32'(free_ready), (fw >= 0) ? (32'd1 << fw) : 32'd0);
        check("grant_valid", 32'(grant_valid), 32'(m_gv));
        check("grant_uid",   32'(grant_uid),   32'(m_guid));
        check("free",        32'(free),        32'(m_free));
        check("free_uid_out", 32'(free_uid_out), 32'(m_fuid));
        check("err",         32'(err),         32'(m_err));
        for (int q = 0; q < NP; q++)
            check($sformatf("outstanding[%0d]", q), 32'(outstanding[q*CW +: CW]), 32'(m_cnt[q]));

        m_gv   = (aw >= 0) ? (1 << aw) : 0;
        m_guid = (aw >= 0) ? au : 0;
        m_free = (fw >= 0) ? 1 : 0;
        if (fw >= 0) begin
            u      = int'(fu[fw*UW +: UW]);
            m_fuid = u;
            if (!m_busy[u] || m_owner[u] != fw) m_err = 1'b1;
            if (m_busy[u]) begin
                o = m_owner[u];
                m_cnt[o]--;
                for (int k = 0; k < held[o].size(); k++)
                    if (held[o][k] == u) begin held[o].delete(k); break; end
            end
            m_busy[u] = 1'b0;
            pool.push_back(u);
            m_fptr = (fw + 1) % NP;
        end else begin
            m_fuid = 0;
        end
        if (aw >= 0) begin
            if (fw >= 0 && u == au) m_err = 1'b1;
            m_owner[au] = aw;
            m_busy[au]  = 1'b1;
            m_cnt[aw]++;
            held[aw].push_back(au);
            m_aptr = (aw + 1) % NP;
            if (pool.size() > 0 && pool[0] == au) void'(pool.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        run_cycle('0, 1'b0, 0, '0, '0);
    endtask

    initial begin
        logic [NP*UW-1:0] fu;
        logic [NP-1:0]    rv, fv;
        logic             ar;
        int               au;

        reset = 1'b1;
        req_valid = '0; alloc_ready = 1'b0; alloc_uid = '0;
        free_valid = '0; free_uid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        idle();

        // Single request, UID 5
        run_cycle(4'b0001, 1'b1, 5, '0, '0);
        idle();

        // All ports requesting for 8 cycles: rotation and credit counts
        for (int i = 0; i < 8; i++) run_cycle(4'b1111, 1'b1, 10 + i, '0, '0);
        idle();

        // Ports 0 and 2 free together; the loser is held for a cycle
        fu = '0;
        fu[0*UW +: UW] = UW'(5);
        fu[2*UW +: UW] = UW'(11);
        run_cycle('0, 1'b0, 0, 4'b0101, fu);
        run_cycle('0, 1'b0, 0, 4'b0100, fu);
        idle();

        // Port 1 frees UID 13, owned by port 0: sticky error
        fu = '0;
        fu[1*UW +: UW] = UW'(13);
        run_cycle('0, 1'b0, 0, 4'b0010, fu);
        idle();
        idle();

        // One port drives its count up to the limit, and is then skipped
        for (int i = 0; i < MO; i++) run_cycle(4'b0010, 1'b1, 20 + i, '0, '0);
        run_cycle(4'b1010, 1'b1, 30, '0, '0);

        // Reset asserted while a grant is on the outputs
        run_cycle(4'b0001, 1'b1, 31, '0, '0);
        reset = 1'b1;
        #1;
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_alloc",       32'(alloc),       32'd0);
        check("rst_req_ready",   32'(req_ready),   32'd0);
        check("rst_free",        32'(free),        32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        req_valid = '0; alloc_ready = 1'b0; free_valid = '0;
        idle();

        // Randomised traffic with legal frees
        for (int c = 0; c < 1500; c++) begin
            rv = NP'($urandom | $urandom);
            ar = (pool.size() > 0) && ($urandom_range(3) != 0);
            au = (pool.size() > 0) ? pool[0] : int'($urandom_range(NE - 1));
            fv = '0;
            fu = '0;
            for (int p = 0; p < NP; p++) begin
                if (held[p].size() > 0 && $urandom_range(2) == 0) begin
                    fv[p] = 1'b1;
                    fu[p*UW +: UW] = UW'(held[p][0]);
                end
            end
            run_cycle(rv, ar, au, fv, fu);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
